// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial add/subtract, LSB first, with carry/borrow out and signed overflow
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic             ai;
  logic             bi;
  logic             bit_out;
  logic             cy_nxt;
  logic             last_bit;
  logic             accept;
  logic             ovf_nxt;

  // One full-adder / full-subtractor slice shared by every bit position
  always_comb begin
    ai       = a_q[cnt];
    bi       = b_q[cnt];
    bit_out  = ai ^ bi ^ cy;
    if (mode_q) begin
      cy_nxt = (ai & bi) | (cy & (ai ^ bi));
    end else begin
      cy_nxt = (~ai & bi) | (~(ai ^ bi) & cy);
    end
    last_bit = (cnt == CW'(WIDTH - 1));
    if (mode_q) begin
      ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bit_out != a_q[WIDTH-1]);
    end else begin
      ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (bit_out != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result bits enter at the MSB so the word ends up LSB-aligned after WIDTH shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      cy     <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      cy     <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      result <= {bit_out, result[WIDTH-1:1]};
      cy     <= cy_nxt;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        cout <= cy_nxt;
        ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - bench for serial_add_sub: WIDTH=8 directed vectors and WIDTH=2 exhaustive sweep
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i [2];
  logic       mode_i  [2];
  logic       cin_i   [2];
  logic [7:0] a_i     [2];
  logic [7:0] b_i     [2];

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] res2;

  logic       busy_o [2];
  logic       done_o [2];
  logic       cout_o [2];
  logic       ovf_o  [2];
  logic [7:0] res_o  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_i[0]), .mode(mode_i[0]),
    .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_i[1]), .mode(mode_i[1]),
    .a(a_i[1][1:0]), .b(b_i[1][1:0]), .cin(cin_i[1]),
    .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2)
  );

  assign busy_o[0] = busy8;
  assign done_o[0] = done8;
  assign cout_o[0] = cout8;
  assign ovf_o[0]  = ovf8;
  assign res_o[0]  = res8;
  assign busy_o[1] = busy2;
  assign done_o[1] = done2;
  assign cout_o[1] = cout2;
  assign ovf_o[1]  = ovf2;
  assign res_o[1]  = {6'b0, res2};

  task automatic chk(input string nm, input int k, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d got=%0h expected=%0h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  // {ovf, cout, result} from plain integer arithmetic on w-bit operands
  function automatic logic [33:0] expect_op(int w, logic m, int av, int bv, logic c);
    longint half, full, sa, sb, sr;
    logic [33:0] r;
    half = longint'(1) << (w - 1);
    full = m ? longint'(av) + longint'(bv) + longint'(c)
             : longint'(av) - longint'(bv) - longint'(c);
    sa = (longint'(av) >= half) ? longint'(av) - 2 * half : longint'(av);
    sb = (longint'(bv) >= half) ? longint'(bv) - 2 * half : longint'(bv);
    sr = m ? sa + sb + longint'(c) : sa - sb - longint'(c);
    r        = '0;
    r[31:0]  = 32'(full & (2 * half - 1));
    r[32]    = m ? (full >= 2 * half) : (full < 0);
    r[33]    = (sr >= half) || (sr < -half);
    return r;
  endfunction

  // Transaction-level model: phase 0 idle, 1 running, 2 done
  int          ph   [2];
  int          rem  [2];
  logic [33:0] pend [2];
  logic [33:0] cur  [2];
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k]  <= 0;
        cur[k] <= '0;
      end else if (ph[k] != 1 && start_i[k]) begin
        pend[k] <= expect_op(k == 0 ? 8 : 2, mode_i[k], int'(a_i[k]), int'(b_i[k]), cin_i[k]);
        rem[k]  <= (k == 0) ? 8 : 2;
        ph[k]   <= 1;
      end else if (ph[k] == 1) begin
        rem[k] <= rem[k] - 1;
        if (rem[k] == 1) begin
          ph[k]  <= 2;
          cur[k] <= pend[k];
        end
      end else if (ph[k] == 2) begin
        ph[k] <= 0;
      end
    end
    if (rst) model_on <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 34'(busy_o[k]), 34'(ph[k] == 1));
        chk("done", k, 34'(done_o[k]), 34'(ph[k] == 2));
        if (ph[k] != 1) begin
          chk("result", k, 34'(res_o[k]), {2'b0, cur[k][31:0]});
          chk("cout", k, 34'(cout_o[k]), 34'(cur[k][32]));
          chk("ovf", k, 34'(ovf_o[k]), 34'(cur[k][33]));
        end
      end
    end
  end

  // Issue one operation on dut k and wait (bounded) for its done pulse
  task automatic run_op(input int k, input logic m, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, output int lat, output int busyc);
    start_i[k] = 1'b1;
    mode_i[k]  = m;
    a_i[k]     = av;
    b_i[k]     = bv;
    cin_i[k]   = c;
    lat   = 0;
    busyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_i[k] = 1'b0;
      lat++;
      if (busy_o[k]) busyc++;
      if (done_o[k]) break;
    end
    chk("done_seen", k, 34'(done_o[k]), 34'(1));
  endtask

  initial begin
    int lat, busyc, dones;
    logic [2:0] e3;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0;
      mode_i[k]  = 1'b0;
      cin_i[k]   = 1'b0;
      a_i[k]     = '0;
      b_i[k]     = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, 34'(busy8), 34'(0));
    chk("rst_done", 0, 34'(done8), 34'(0));
    chk("rst_result", 0, 34'(res8), 34'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 1'b0, 8'd5, 8'd3, 1'b0, lat, busyc);
    chk("sub5_3_latency", 0, 34'(lat), 34'(9));
    chk("sub5_3_busy_cycles", 0, 34'(busyc), 34'(8));
    chk("sub5_3_result", 0, 34'(res8), 34'h02);
    chk("sub5_3_cout", 0, 34'(cout8), 34'(0));
    chk("sub5_3_ovf", 0, 34'(ovf8), 34'(0));
    repeat (2) @(negedge clk);

    run_op(0, 1'b0, 8'd3, 8'd5, 1'b0, lat, busyc);
    chk("sub3_5_result", 0, 34'(res8), 34'hFE);
    chk("sub3_5_cout", 0, 34'(cout8), 34'(1));
    chk("sub3_5_ovf", 0, 34'(ovf8), 34'(0));

    run_op(0, 1'b0, 8'h80, 8'h01, 1'b0, lat, busyc);
    chk("sub80_01_result", 0, 34'(res8), 34'h7F);
    chk("sub80_01_cout", 0, 34'(cout8), 34'(0));
    chk("sub80_01_ovf", 0, 34'(ovf8), 34'(1));

    run_op(0, 1'b1, 8'hFF, 8'h01, 1'b0, lat, busyc);
    chk("addFF_01_result", 0, 34'(res8), 34'h00);
    chk("addFF_01_cout", 0, 34'(cout8), 34'(1));
    chk("addFF_01_ovf", 0, 34'(ovf8), 34'(0));

    run_op(0, 1'b1, 8'h7F, 8'h01, 1'b0, lat, busyc);
    chk("add7F_01_result", 0, 34'(res8), 34'h80);
    chk("add7F_01_ovf", 0, 34'(ovf8), 34'(1));
    repeat (2) @(negedge clk);

    // Restart attempt and operand churn while running must not disturb 5-3
    start_i[0] = 1'b1; mode_i[0] = 1'b0; a_i[0] = 8'd5; b_i[0] = 8'd3; cin_i[0] = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_i[0] = 1'b0;
      lat++;
      if (lat == 3) begin
        start_i[0] = 1'b1; mode_i[0] = 1'b1; a_i[0] = 8'hAA; b_i[0] = 8'h11; cin_i[0] = 1'b1;
      end
      if (lat == 5) begin
        a_i[0] = 8'h3C; b_i[0] = 8'hC3;
      end
      if (done8) break;
    end
    chk("midrun_latency", 0, 34'(lat), 34'(9));
    chk("midrun_result", 0, 34'(res8), 34'h02);
    repeat (2) @(negedge clk);

    start_i[0] = 1'b1; mode_i[0] = 1'b1; a_i[0] = 8'h12; b_i[0] = 8'h34; cin_i[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start_i[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 0, 34'(busy8), 34'(0));
    chk("abort_done", 0, 34'(done8), 34'(0));
    chk("abort_result", 0, 34'(res8), 34'(0));
    chk("abort_cout", 0, 34'(cout8), 34'(0));
    chk("abort_ovf", 0, 34'(ovf8), 34'(0));
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("abort_no_done", 0, 34'(dones), 34'(0));
    run_op(0, 1'b0, 8'd3, 8'd5, 1'b0, lat, busyc);
    chk("after_rst_latency", 0, 34'(lat), 34'(9));
    chk("after_rst_result", 0, 34'(res8), 34'hFE);
    chk("after_rst_cout", 0, 34'(cout8), 34'(1));
    repeat (2) @(negedge clk);

    // WIDTH=2: every {mode,a,b,cin}, each start issued in the DONE cycle of the previous op
    for (int v = 0; v < 64; v++) begin
      logic       m, c;
      logic [1:0] av, bv;
      {m, av, bv, c} = 6'(v);
      run_op(1, m, {6'b0, av}, {6'b0, bv}, c, lat, busyc);
      e3 = m ? 3'(av + bv + c) : 3'(av - bv - c);
      chk("w2_latency", 1, 34'(lat), 34'(3));
      chk("w2_result", 1, 34'(res2), 34'(e3[1:0]));
      chk("w2_cout", 1, 34'(cout2), 34'(e3[2]));
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1, an operation request sampled on a clk edge.
REQ-005 The block SHALL have port mode, input, 1, selecting the operation: 0 = subtract (a-b-bin), 1 = add (a+b+cin).
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the operands.
REQ-007 The block SHALL have port cin, input, 1, the borrow-in for subtract or the carry-in for add.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, WIDTH, the difference or sum.
REQ-011 The block SHALL have port cout, output, 1, the borrow-out for subtract or the carry-out for add.
REQ-012 The block SHALL have port ovf, output, 1, the two's-complement signed overflow flag.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 When start=1 in IDLE or DONE, the block SHALL:
- latch a, b, mode and cin;
- clear the bit counter;
- enter RUN.
REQ-015 When start=0 in IDLE, the block SHALL stay in IDLE.
REQ-016 When start=0 in DONE, the block SHALL return to IDLE after one cycle.
REQ-017 In RUN, the block SHALL process one bit per cycle, LSB first, using a one-bit carry/borrow flip-flop initialised from the latched cin.
REQ-018 Per-bit subtract SHALL be: d = ai^bi^br; br' = (~ai&bi) | (~(ai^bi)&br).
REQ-019 Per-bit add SHALL be: s = ai^bi^c; c' = (ai&bi) | (c&(ai^bi)).
REQ-020 The block SHALL shift each result bit into the result shift register from the MSB end, so that after WIDTH bits the register holds the result LSB-aligned.
REQ-021 After the WIDTH-th bit the block SHALL enter DONE.
REQ-022 On entering DONE, the block SHALL:
- set cout to the final carry/borrow flip-flop value;
- compute ovf.
REQ-023 ovf for subtract SHALL be (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
REQ-024 ovf for add SHALL be (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
REQ-025 busy SHALL be 1 exactly in RUN.
REQ-026 done SHALL be 1 exactly in DONE.
REQ-027 Latency: with start sampled at edge T, done SHALL be high during the cycle after edge T+WIDTH, i.e. WIDTH+1 edges after start.
REQ-028 The block SHALL ignore start while in RUN, with no effect on the latched operands or the counter.
REQ-029 The block SHALL ignore changes on a, b, mode and cin after latch, until the next accepted start.
REQ-030 result, cout and ovf SHALL hold their last completed values from DONE until the next accepted start.
REQ-031 result, cout and ovf MAY change during RUN and are valid only while done=1 and afterwards.
REQ-032 All arithmetic SHALL be modulo 2^WIDTH; no bits other than cout and ovf SHALL be reported.

Reset
REQ-033 While rst=1 at a clk edge, the block SHALL:
- enter IDLE;
- clear busy, done, result, cout, ovf, the counter and the carry/borrow flip-flop to 0.
REQ-034 rst SHALL take priority over start.
REQ-035 rst asserted in RUN SHALL abort the operation with no done pulse.
REQ-036 The first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-037 The bench SHALL drive mode=0, a=5, b=3, cin=0, start one cycle, and check:
- result=8'h02, cout=0, ovf=0;
- done high exactly 9 edges after start;
- busy high for 8 cycles.
REQ-038 The bench SHALL drive mode=0, a=3, b=5, cin=0 and check result=8'hFE, cout=1, ovf=0.
REQ-039 The bench SHALL drive mode=0, a=8'h80, b=8'h01, cin=0 and check result=8'h7F, cout=0, ovf=1.
REQ-040 The bench SHALL drive two add cases and check both:
- mode=1, a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1, ovf=0;
- mode=1, a=8'h7F, b=8'h01 -> result=8'h80, ovf=1.
REQ-041 The bench SHALL pulse start again mid-RUN with different operands and check that the original result is delivered on schedule.
REQ-042 The bench SHALL then assert rst for one cycle mid-RUN and check:
- no done pulse;
- all outputs 0;
- the next start completes correctly.
REQ-043 With WIDTH=2, the bench SHALL apply all 64 combinations of {mode,a,b,cin} and check result and cout against {cout,result} = a-b-cin or a+b+cin, back-to-back using start in DONE.
